// File: rtl/jtag_tap_states_pkg.sv
// Shared TAP state codes (IEEE 1149.1 encoding), imported by the controller and its benches.
package JTAG_TAP_states_pkg;

   typedef enum logic [3:0] {
      TAP_EX2_DR   = 4'h0, TAP_EX1_DR   = 4'h1, TAP_SH_DR  = 4'h2, TAP_PAUSE_DR = 4'h3,
      TAP_SEL_IR   = 4'h4, TAP_UPD_DR   = 4'h5, TAP_CAP_DR = 4'h6, TAP_SEL_DR   = 4'h7,
      TAP_EX2_IR   = 4'h8, TAP_EX1_IR   = 4'h9, TAP_SH_IR  = 4'hA, TAP_PAUSE_IR = 4'hB,
      TAP_RTI      = 4'hC, TAP_UPD_IR   = 4'hD, TAP_CAP_IR = 4'hE, TAP_TLR      = 4'hF
   } tap_state_e;

   localparam logic [3:0] TLR      = 4'hF;
   localparam logic [3:0] RTI      = 4'hC;
   localparam logic [3:0] SEL_DR   = 4'h7;
   localparam logic [3:0] CAP_DR   = 4'h6;
   localparam logic [3:0] SH_DR    = 4'h2;
   localparam logic [3:0] EX1_DR   = 4'h1;
   localparam logic [3:0] PAUSE_DR = 4'h3;
   localparam logic [3:0] EX2_DR   = 4'h0;
   localparam logic [3:0] UPD_DR   = 4'h5;
   localparam logic [3:0] SEL_IR   = 4'h4;
   localparam logic [3:0] CAP_IR   = 4'hE;
   localparam logic [3:0] SH_IR    = 4'hA;
   localparam logic [3:0] EX1_IR   = 4'h9;
   localparam logic [3:0] PAUSE_IR = 4'hB;
   localparam logic [3:0] EX2_IR   = 4'h8;
   localparam logic [3:0] UPD_IR   = 4'hD;

endpackage

// File: rtl/jtag_rti_counter.sv
// Saturating count of consecutive TCK edges spent staying in Run-Test/Idle.
module jtag_rti_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stay,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (!stay)
         count <= '0;
      else if (count != '1)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP state machine with Moore-decoded IR/DR control flags.
// Optional Run-Test/Idle counter enabled by macro JTAG_TAP_RTI_COUNTER_EN.
module jtag_tap_controller
   import JTAG_TAP_states_pkg::*;
#(
   parameter int RTI_COUNT_WIDTH = 8
) (
   input  logic                       TCK,
   input  logic                       RESET,
   input  logic                       TMS,
   output logic [3:0]                 TAP_STATE,
   output logic                       TEST_LOGIC_RESET,
   output logic                       CAPTURE_IR,
   output logic                       SHIFT_IR,
   output logic                       UPDATE_IR,
   output logic                       CAPTURE_DR,
   output logic                       SHIFT_DR,
   output logic                       UPDATE_DR,
   output logic                       SELECT_IR,
   output logic                       TDO_ENABLE,
   output logic [RTI_COUNT_WIDTH-1:0] RTI_COUNT
);

   logic [3:0] state;
   logic [3:0] next_state;

   always_comb begin
      next_state = TLR;
      case (state)
         TLR:      next_state = TMS ? TLR      : RTI;
         RTI:      next_state = TMS ? SEL_DR   : RTI;
         SEL_DR:   next_state = TMS ? SEL_IR   : CAP_DR;
         CAP_DR:   next_state = TMS ? EX1_DR   : SH_DR;
         SH_DR:    next_state = TMS ? EX1_DR   : SH_DR;
         EX1_DR:   next_state = TMS ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: next_state = TMS ? EX2_DR   : PAUSE_DR;
         EX2_DR:   next_state = TMS ? UPD_DR   : SH_DR;
         UPD_DR:   next_state = TMS ? SEL_DR   : RTI;
         SEL_IR:   next_state = TMS ? TLR      : CAP_IR;
         CAP_IR:   next_state = TMS ? EX1_IR   : SH_IR;
         SH_IR:    next_state = TMS ? EX1_IR   : SH_IR;
         EX1_IR:   next_state = TMS ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: next_state = TMS ? EX2_IR   : PAUSE_IR;
         EX2_IR:   next_state = TMS ? UPD_IR   : SH_IR;
         UPD_IR:   next_state = TMS ? SEL_DR   : RTI;
         default:  next_state = TLR;
      endcase
   end

   always_ff @(posedge TCK) begin
      if (!RESET)
         state <= TLR;
      else
         state <= next_state;
   end

   // Every flag decodes the registered state only, so TMS never reaches an output combinationally.
   assign TAP_STATE        = state;
   assign TEST_LOGIC_RESET = (state == TLR);
   assign CAPTURE_IR       = (state == CAP_IR);
   assign SHIFT_IR         = (state == SH_IR);
   assign UPDATE_IR        = (state == UPD_IR);
   assign CAPTURE_DR       = (state == CAP_DR);
   assign SHIFT_DR         = (state == SH_DR);
   assign UPDATE_DR        = (state == UPD_DR);
   assign TDO_ENABLE       = (state == SH_IR) || (state == SH_DR);
   assign SELECT_IR        = (state == SEL_IR) || (state == CAP_IR) || (state == SH_IR)
                          || (state == EX1_IR) || (state == PAUSE_IR) || (state == EX2_IR)
                          || (state == UPD_IR);

`ifdef JTAG_TAP_RTI_COUNTER_EN
   logic rti_stay;
   assign rti_stay = (state == RTI) && (next_state == RTI);

   jtag_rti_counter #(
      .WIDTH (RTI_COUNT_WIDTH)
   ) u_rti_counter (
      .clk   (TCK),
      .rst_n (RESET),
      .stay  (rti_stay),
      .count (RTI_COUNT)
   );
`else
   assign RTI_COUNT = '0;
`endif

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: table-driven TAP model checked every cycle plus literal checks.
module tb_jtag_tap_controller;
   import JTAG_TAP_states_pkg::*;

   localparam int W = 4;

   logic         TCK = 1'b0;
   logic         RESET = 1'b0;
   logic         TMS = 1'b1;
   logic [3:0]   TAP_STATE;
   logic         TEST_LOGIC_RESET, CAPTURE_IR, SHIFT_IR, UPDATE_IR;
   logic         CAPTURE_DR, SHIFT_DR, UPDATE_DR, SELECT_IR, TDO_ENABLE;
   logic [W-1:0] RTI_COUNT;

   jtag_tap_controller #(.RTI_COUNT_WIDTH(W)) dut (
      .TCK(TCK), .RESET(RESET), .TMS(TMS), .TAP_STATE(TAP_STATE),
      .TEST_LOGIC_RESET(TEST_LOGIC_RESET),
      .CAPTURE_IR(CAPTURE_IR), .SHIFT_IR(SHIFT_IR), .UPDATE_IR(UPDATE_IR),
      .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR),
      .SELECT_IR(SELECT_IR), .TDO_ENABLE(TDO_ENABLE), .RTI_COUNT(RTI_COUNT)
   );

   always #5 TCK = ~TCK;

   int vectors = 0;
   int miscompares = 0;

   // Transition table written straight from the TAP diagram, indexed by state code.
   logic [3:0] nxt0 [16];
   logic [3:0] nxt1 [16];
   logic [7:0] pbits [16];
   int         plen  [16];

   logic [3:0] m_state = 4'hF;
   int         m_run = 0;
   bit         m_valid = 1'b0;

   always @(posedge TCK) begin
      if (!RESET) begin
         m_state <= 4'hF;
         m_run   <= 0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         m_state <= TMS ? nxt1[m_state] : nxt0[m_state];
         m_run   <= (m_state == 4'hC && !TMS) ? m_run + 1 : 0;
      end
   end

   function automatic logic [3:0] exp_count(input int run);
`ifdef JTAG_TAP_RTI_COUNTER_EN
      return (run > 15) ? 4'd15 : 4'(run);
`else
      return 4'd0;
`endif
   endfunction

   function automatic bit in_ir_column(input logic [3:0] s);
      return s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [16:0] e, a;
      e = {m_state, m_state == 4'hF, m_state == 4'hE, m_state == 4'hA, m_state == 4'hD,
           m_state == 4'h6, m_state == 4'h2, m_state == 4'h5, in_ir_column(m_state),
           (m_state == 4'hA || m_state == 4'h2), exp_count(m_run)};
      a = {TAP_STATE, TEST_LOGIC_RESET, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR,
           SHIFT_DR, UPDATE_DR, SELECT_IR, TDO_ENABLE, RTI_COUNT};
      chk("model", 32'(a), 32'(e));
      chk("onehot", 32'($countones({CAPTURE_IR, SHIFT_IR, UPDATE_IR,
                                     CAPTURE_DR, SHIFT_DR, UPDATE_DR}) <= 1), 32'd1);
   endtask

   task automatic step(input logic tms, input logic rst = 1'b1);
      TMS = tms;
      RESET = rst;
      @(posedge TCK);
      #1;
      check_model();
   endtask

   task automatic walk(input int s);
      for (int i = plen[s] - 1; i >= 0; i--) step(pbits[s][i]);
   endtask

   initial begin
      int sh;
      nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
      nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
      nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
      nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
      nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
      nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
      nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
      nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
      nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
      nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
      nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
      nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
      nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
      nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
      nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
      nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;
      // TMS paths from TLR to each state, first bit applied is the MSB of the length.
      pbits[4'hF] = 8'b0;       plen[4'hF] = 0;
      pbits[4'hC] = 8'b0;       plen[4'hC] = 1;
      pbits[4'h7] = 8'b01;      plen[4'h7] = 2;
      pbits[4'h6] = 8'b010;     plen[4'h6] = 3;
      pbits[4'h2] = 8'b0100;    plen[4'h2] = 4;
      pbits[4'h1] = 8'b0101;    plen[4'h1] = 4;
      pbits[4'h3] = 8'b01010;   plen[4'h3] = 5;
      pbits[4'h0] = 8'b010101;  plen[4'h0] = 6;
      pbits[4'h5] = 8'b01011;   plen[4'h5] = 5;
      pbits[4'h4] = 8'b011;     plen[4'h4] = 3;
      pbits[4'hE] = 8'b0110;    plen[4'hE] = 4;
      pbits[4'hA] = 8'b01100;   plen[4'hA] = 5;
      pbits[4'h9] = 8'b01101;   plen[4'h9] = 5;
      pbits[4'hB] = 8'b011010;  plen[4'hB] = 6;
      pbits[4'h8] = 8'b0110101; plen[4'h8] = 7;
      pbits[4'hD] = 8'b011011;  plen[4'hD] = 6;

      // Reset state, with TMS low during reset
      step(1'b0, 1'b0);
      chk("rst_state", 32'(TAP_STATE), 32'hF);
      chk("rst_tlr", 32'(TEST_LOGIC_RESET), 32'd1);
      chk("rst_flags", 32'({CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
                            SELECT_IR, TDO_ENABLE}), 32'd0);
      chk("rst_count", 32'(RTI_COUNT), 32'd0);

      // Reset takes priority mid-scan from Shift-DR
      walk(4'h2);
      chk("at_shdr", 32'(SHIFT_DR), 32'd1);
      step(1'b0, 1'b0);
      chk("rst_from_shdr", 32'(TAP_STATE), 32'hF);
      chk("rst_from_shdr_tlr", 32'(TEST_LOGIC_RESET), 32'd1);
      chk("rst_from_shdr_sdr", 32'(SHIFT_DR), 32'd0);

      // IR scan entry and shift/update
      step(1'b0); chk("ir_c", 32'(TAP_STATE), 32'hC); chk("ir_c_sel", 32'(SELECT_IR), 32'd0);
      step(1'b1); chk("ir_7", 32'(TAP_STATE), 32'h7); chk("ir_7_sel", 32'(SELECT_IR), 32'd0);
      step(1'b1); chk("ir_4", 32'(TAP_STATE), 32'h4); chk("ir_4_sel", 32'(SELECT_IR), 32'd1);
      step(1'b0); chk("ir_e", 32'(TAP_STATE), 32'hE); chk("ir_e_cap", 32'(CAPTURE_IR), 32'd1);
      step(1'b0); chk("ir_a", 32'(TAP_STATE), 32'hA); chk("ir_a_cap", 32'(CAPTURE_IR), 32'd0);
      chk("ir_a_tdo", 32'(TDO_ENABLE), 32'd1);
      sh = int'(SHIFT_IR);
      repeat (5) begin step(1'b0); sh += int'(SHIFT_IR); end
      step(1'b1); sh += int'(SHIFT_IR);
      chk("shift_ir_cycles", 32'(sh), 32'd6);
      chk("ir_9", 32'(TAP_STATE), 32'h9);
      step(1'b1); chk("ir_d", 32'(TAP_STATE), 32'hD); chk("ir_d_upd", 32'(UPDATE_IR), 32'd1);
      step(1'b0); chk("ir_after_upd", 32'(UPDATE_IR), 32'd0);
      chk("ir_back_rti", 32'(TAP_STATE), 32'hC);

      // Run-Test/Idle counter: enter RTI, hold 20 cycles, then leave
      step(1'b1, 1'b0);
      step(1'b0);
      chk("rti_entry", 32'(RTI_COUNT), 32'd0);
      for (int k = 1; k <= 20; k++) begin
         step(1'b0);
`ifdef JTAG_TAP_RTI_COUNTER_EN
         chk("rti_count", 32'(RTI_COUNT), (k > 15) ? 32'd15 : 32'(k));
`else
         chk("rti_count", 32'(RTI_COUNT), 32'd0);
`endif
      end
      step(1'b1);
      chk("rti_exit_state", 32'(TAP_STATE), 32'h7);
      chk("rti_exit_count", 32'(RTI_COUNT), 32'd0);

      // Every state x every TMS value, then five TMS=1 back to TLR
      for (int s = 0; s < 16; s++) begin
         for (int t = 0; t < 2; t++) begin
            step(1'b1, 1'b0);
            walk(s);
            chk("path", 32'(TAP_STATE), 32'(s));
            step(t[0]);
            repeat (5) step(1'b1);
            chk("tms5_tlr", 32'(TAP_STATE), 32'hF);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
